uart_program_loader: RTL and testbench



---
 rtl/uart_program_loader.sv | 201 ++++++++++++++++++++
 tb/tb_uart_program_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// Serial program loader: receives 8N1 UART bytes, packs them little-endian into
// 32-bit words and strobes each word out with a word-aligned byte address.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MEM_BYTES    = 4096,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        io_rx,
    output logic        data_valid,
    output logic [31:0] data_out,
    output logic [31:0] byte_address,
    output logic        frame_error
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);
    localparam int ADDR_W = $clog2(MEM_BYTES);
    localparam logic [CNT_W-1:0] HALF_LAST    = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    logic              rx_meta_r;
    logic              rx_sync_r;
    state_t            state_r;
    state_t            state_next_s;
    logic [CNT_W-1:0]  clk_cnt_r;
    logic [CNT_W-1:0]  clk_cnt_next_s;
    logic [2:0]        bit_idx_r;
    logic [2:0]        bit_idx_next_s;
    logic [7:0]        shift_r;
    logic [7:0]        shift_next_s;
    logic              byte_ok_s;
    logic              byte_bad_s;
    logic [1:0]        byte_cnt_r;
    logic [23:0]       word_r;
    logic [31:0]       idle_cnt_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic              data_valid_r;
    logic              frame_error_r;
    logic [31:0]       data_out_r;
    logic [31:0]       byte_address_r;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= io_rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receiver state register with bit timer, bit index and shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            clk_cnt_r <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
        end else begin
            state_r   <= state_next_s;
            clk_cnt_r <= clk_cnt_next_s;
            bit_idx_r <= bit_idx_next_s;
            shift_r   <= shift_next_s;
        end
    end

    // Receiver next-state logic; all samples are taken at mid-bit.
    always_comb begin
        state_next_s   = state_r;
        clk_cnt_next_s = clk_cnt_r;
        bit_idx_next_s = bit_idx_r;
        shift_next_s   = shift_r;
        byte_ok_s      = 1'b0;
        byte_bad_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clk_cnt_next_s = '0;
                if (!rx_sync_r) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (clk_cnt_r == HALF_LAST) begin
                    clk_cnt_next_s = '0;
                    bit_idx_next_s = 3'd0;
                    if (!rx_sync_r) begin
                        state_next_s = ST_DATA;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    clk_cnt_next_s = clk_cnt_r + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (clk_cnt_r == BIT_LAST) begin
                    clk_cnt_next_s = '0;
                    shift_next_s   = {rx_sync_r, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_next_s = ST_STOP;
                    end else begin
                        bit_idx_next_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    clk_cnt_next_s = clk_cnt_r + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (clk_cnt_r == BIT_LAST) begin
                    clk_cnt_next_s = '0;
                    if (rx_sync_r) begin
                        byte_ok_s    = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        byte_bad_s   = 1'b1;
                        state_next_s = ST_RECOVER;
                    end
                end else begin
                    clk_cnt_next_s = clk_cnt_r + CNT_W'(1);
                end
            end
            ST_RECOVER: begin
                clk_cnt_next_s = '0;
                if (rx_sync_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RECOVER;
                end
            end
            default: begin
                state_next_s   = ST_IDLE;
                clk_cnt_next_s = '0;
            end
        endcase
    end

    // Word assembly, address generation, partial-word timeout and output strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt_r     <= 2'd0;
            word_r         <= 24'd0;
            idle_cnt_r     <= 32'd0;
            wr_addr_r      <= '0;
            data_valid_r   <= 1'b0;
            frame_error_r  <= 1'b0;
            data_out_r     <= 32'd0;
            byte_address_r <= 32'd0;
        end else begin
            data_valid_r  <= 1'b0;
            frame_error_r <= 1'b0;
            if (byte_bad_s) begin
                byte_cnt_r    <= 2'd0;
                idle_cnt_r    <= 32'd0;
                frame_error_r <= 1'b1;
            end else if (byte_ok_s) begin
                idle_cnt_r <= 32'd0;
                case (byte_cnt_r)
                    2'd0: word_r[7:0]   <= shift_r;
                    2'd1: word_r[15:8]  <= shift_r;
                    2'd2: word_r[23:16] <= shift_r;
                    default: begin
                        data_out_r     <= {shift_r, word_r};
                        byte_address_r <= {{(32 - ADDR_W){1'b0}}, wr_addr_r};
                        data_valid_r   <= 1'b1;
                        wr_addr_r      <= wr_addr_r + ADDR_W'(4);
                    end
                endcase
                byte_cnt_r <= byte_cnt_r + 2'd1;
            end else if (state_r == ST_IDLE && byte_cnt_r != 2'd0) begin
                // A stalled partial word is dropped; the address does not move.
                if (idle_cnt_r == TIMEOUT_LAST) begin
                    byte_cnt_r <= 2'd0;
                    idle_cnt_r <= 32'd0;
                end else begin
                    idle_cnt_r <= idle_cnt_r + 32'd1;
                end
            end else begin
                idle_cnt_r <= 32'd0;
            end
        end
    end

    assign data_valid   = data_valid_r;
    assign frame_error  = frame_error_r;
    assign data_out     = data_out_r;
    assign byte_address = byte_address_r;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed/randomized bench for uart_program_loader with a byte-queue reference model.
module tb_uart_program_loader;

    localparam int CPB = 16;
    localparam int MEM = 16;
    localparam int TOB = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        io_rx = 1'b1;
    logic        data_valid;
    logic [31:0] data_out;
    logic [31:0] byte_address;
    logic        frame_error;

    int total = 0;
    int bad = 0;

    logic [31:0] obs_data_q[$];
    logic [31:0] obs_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] exp_addr_q[$];
    int obs_ferr = 0;
    int exp_ferr = 0;
    int obs_overlap = 0;
    logic [7:0] model_bytes[$];
    int model_addr = 0;

    always #5 clk = ~clk;

    uart_program_loader #(
        .CLKS_PER_BIT(CPB),
        .MEM_BYTES(MEM),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .io_rx(io_rx),
        .data_valid(data_valid),
        .data_out(data_out),
        .byte_address(byte_address),
        .frame_error(frame_error)
    );

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (data_valid) begin
                obs_data_q.push_back(data_out);
                obs_addr_q.push_back(byte_address);
            end
            if (frame_error) begin
                obs_ferr++;
                if (data_valid) obs_overlap++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: accepted bytes form words four at a time; bad frames drop the partial word.
    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            model_bytes.delete();
            exp_ferr++;
        end else begin
            model_bytes.push_back(b);
            if (model_bytes.size() == 4) begin
                exp_data_q.push_back({model_bytes[3], model_bytes[2], model_bytes[1], model_bytes[0]});
                exp_addr_q.push_back(32'(model_addr));
                model_addr = (model_addr + 4) % MEM;
                model_bytes.delete();
            end
        end
    endtask

    task automatic idle_bits(input int n);
        io_rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
        if (n > TOB) model_bytes.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good);
        io_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            io_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        io_rx = good;
        repeat (CPB) @(negedge clk);
        if (!good) begin
            io_rx = 1'b1;
            repeat (2 * CPB) @(negedge clk);
        end
        model_byte(b, good);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        io_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_bytes.delete();
        model_addr = 0;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic check_step(input string tag);
        int n;
        check({tag, "_count"}, 32'(obs_data_q.size()), 32'(exp_data_q.size()));
        n = (obs_data_q.size() < exp_data_q.size()) ? obs_data_q.size() : exp_data_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, obs_data_q[i], exp_data_q[i]);
            check({tag, "_addr"}, obs_addr_q[i], exp_addr_q[i]);
        end
        check({tag, "_ferr"}, 32'(obs_ferr), 32'(exp_ferr));
        check({tag, "_overlap"}, 32'(obs_overlap), 32'd0);
        obs_data_q.delete();
        obs_addr_q.delete();
        exp_data_q.delete();
        exp_addr_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_addr", byte_address, 32'd0);
        check("rst_ferr", {31'd0, frame_error}, 32'd0);
        reset_n = 1'b1;
        repeat (CPB) @(negedge clk);

        // First word, then outputs must hold.
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h50, 1'b1);
        send_byte(8'h00, 1'b1);
        idle_bits(2);
        check_step("word1");
        idle_bits(4);
        check("hold_data", data_out, 32'h00500013);
        check("hold_addr", byte_address, 32'd0);
        check("hold_valid", {31'd0, data_valid}, 32'd0);

        // Three back-to-back words ending with the run token.
        do_reset();
        send_word($urandom);
        send_word($urandom);
        send_word(32'h00001111);
        idle_bits(2);
        check_step("b2b");
        check("token_data", data_out, 32'h00001111);
        check("token_addr", byte_address, 32'd8);

        // Short low glitch must not start a frame.
        do_reset();
        io_rx = 1'b0;
        repeat (4) @(negedge clk);
        io_rx = 1'b1;
        idle_bits(2);
        check_step("glitch_none");
        send_word($urandom);
        idle_bits(2);
        check_step("glitch_word");
        check("glitch_addr", byte_address, 32'd0);

        // Bad stop bit drops the byte, then a clean word.
        do_reset();
        send_byte(8'($urandom), 1'b0);
        send_word($urandom);
        idle_bits(2);
        check_step("ferr");
        check("ferr_addr", byte_address, 32'd0);

        // Partial word times out.
        do_reset();
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b1);
        idle_bits(40);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        idle_bits(2);
        check_step("timeout");
        check("timeout_data", data_out, 32'hDDCCBBAA);

        // Address wraps at MEM_BYTES.
        do_reset();
        for (int i = 0; i < 5; i++) send_word($urandom);
        idle_bits(2);
        check_step("wrap");
        check("wrap_addr", byte_address, 32'd0);

        // Reset in the middle of the second byte.
        send_word($urandom);
        idle_bits(2);
        check_step("pre_rst");
        send_byte(8'($urandom), 1'b1);
        io_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            io_rx = 1'($urandom);
            repeat (CPB) @(negedge clk);
        end
        repeat (CPB / 2) @(negedge clk);
        reset_n = 1'b0;
        io_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_valid", {31'd0, data_valid}, 32'd0);
        check("midrst_data", data_out, 32'd0);
        check("midrst_addr", byte_address, 32'd0);
        check("midrst_ferr", {31'd0, frame_error}, 32'd0);
        reset_n = 1'b1;
        model_bytes.delete();
        model_addr = 0;
        idle_bits(2);
        send_word($urandom);
        idle_bits(2);
        check_step("post_rst");
        check("post_rst_addr", byte_address, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
